pwm_capture: RTL
================

Name: pwm_capture

Overview:
- Receive-side counterpart of the PWM generator. It measures an incoming PWM/servo-style signal: high time and period, in clk_in cycles.
- It also decodes the measured pulse width back into the 8-bit control code space used by the generator (0 = short pulse, 2 = long pulse).
- It sits at the board-input boundary, feeding measured values to the control logic and status registers.

Parameters:
- CNT_W, 20: width of all cycle counters and measurement outputs.
- SYNC_STAGES, 2: input synchroniser depth; legal range is 2 or more.
- FILTER_LEN, 4: consecutive cycles a new synchronised level must persist before it is accepted; legal range is 1 or more.
- TIMEOUT, 200000: cycles without the expected edge before the signal is declared lost. Must be less than 2^CNT_W-1.
- DECODE_THRESH, 7500: high_cnt strictly greater than this decodes to ctrl_out=2; otherwise ctrl_out=0.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous, active-low reset
- pwm_in  input  1  asynchronous PWM input
- high_cnt  output  CNT_W  high time of the last complete period, in cycles
- period_cnt  output  CNT_W  rising-to-rising period of the last complete period, in cycles
- ctrl_out  output  8  decoded control code for the last complete period
- meas_valid  output  1  one-cycle strobe; high_cnt, period_cnt and ctrl_out were updated this cycle
- signal_lost  output  1  level; no valid signal present

Behaviour:
- Reset (rst_in=0, asynchronous, effective immediately, including mid-measurement):
  - high_cnt=0, period_cnt=0, ctrl_out=0, meas_valid=0, signal_lost=1.
  - Synchroniser and filter registers are set to 0; the FSM goes to IDLE.
- Synchroniser: SYNC_STAGES flops, reset 0.
- Glitch filter:
  - The filtered level register changes only after the synchronised level has differed from it for FILTER_LEN consecutive cycles.
  - Any agreeing cycle clears the disagreement counter.
  - Pulses or blips shorter than FILTER_LEN cycles are ignored.
- Edge detect: compare filtered against its one-cycle-delayed copy to produce rise and fall strobes.
- Cycle counter cnt: cleared to 0 on every accepted rise; +1 per cycle otherwise, saturating at 2^CNT_W-1.
- FSM states IDLE, HIGH, LOW:
  - IDLE: cnt is held at 0. On rise, go to HIGH. A fall in IDLE is ignored.
  - HIGH: on fall, latch hi_lat=cnt and go to LOW. If cnt==TIMEOUT, go to IDLE and set signal_lost=1.
  - LOW: on rise:
    - high_cnt<=hi_lat, period_cnt<=cnt.
    - ctrl_out<=(hi_lat>DECODE_THRESH)?2:0.
    - meas_valid=1 for exactly one cycle, signal_lost<=0.
    - Clear cnt and go to HIGH.
  - LOW, timeout: if cnt==TIMEOUT, go to IDLE, set signal_lost=1, no meas_valid.
- Output hold: outputs hold their last values between strobes and after timeout. They are cleared only by reset.
- First measurement: the first strobe after reset or after signal loss needs two accepted rising edges.
- Simultaneous events: a rise and cnt==TIMEOUT in the same cycle in LOW resolve as a valid measurement, since the rise takes priority.
- Latency and accuracy:
  - From the pwm_in edge to the corresponding internal strobe is a fixed SYNC_STAGES+FILTER_LEN+1 cycles.
  - Both edges see the same delay, so for a clean input held H cycles high and L cycles low, high_cnt=H and period_cnt=H+L exactly.
  - meas_valid is registered and asserts on the cycle after the rise strobe.

Test Plan:
1. Clean waveform, 5001 high / 95000 low, repeated 3 periods: two meas_valid strobes, each with high_cnt=5001, period_cnt=100001, ctrl_out=0. signal_lost goes 1→0 at the first strobe.
2. Same waveform with 10001 high / 90000 low: high_cnt=10001, period_cnt=100001, ctrl_out=2. Also sweep high to 7500 (ctrl_out=0) and 7501 (ctrl_out=2).
3. Glitches with FILTER_LEN=4:
   - A 3-cycle low blip mid-high is ignored; high_cnt=5001.
   - A 4-cycle low blip is accepted; high_cnt equals the cycles before the blip, and the blip's end starts a new period.
4. Timeouts:
   - After valid periods, hold pwm_in low: signal_lost=1 exactly when cnt reaches 200000, no strobe, outputs keep the last values.
   - Hold pwm_in high instead: same timeout result from HIGH.
   - Resume the waveform: a strobe follows only after the second rise.
5. Assert rst_in=0 mid-high for 3 cycles: all outputs return to reset values immediately. After release, no strobe until two rises, then correct values.
6. Apply a first falling edge while in IDLE, then regular pulses: the fall is ignored, and the first strobe reports exact values with no partial period.

Source files
------------

// File: rtl/pwm_capture_if.sv
// rtl/pwm_capture_if.sv - PWM input and measurement result bundle for pwm_capture
interface pwm_capture_if #(
  parameter int CNT_W = 20
);
  logic             pwm_in;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic [7:0]       ctrl_out;
  logic             meas_valid;
  logic             signal_lost;

  modport master (
    output pwm_in,
    input  high_cnt, period_cnt, ctrl_out, meas_valid, signal_lost
  );

  modport slave (
    input  pwm_in,
    output high_cnt, period_cnt, ctrl_out, meas_valid, signal_lost
  );
endinterface

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - measures high time and period of an async PWM input and decodes the control code
module pwm_capture #(
  parameter int CNT_W         = 20,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_LEN    = 4,
  parameter int TIMEOUT       = 200000,
  parameter int DECODE_THRESH = 7500
) (
  input  logic         clk_in,
  input  logic         rst_in,
  pwm_capture_if.slave bus
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FW-1:0]    FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TO_CNT    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] THRESH    = CNT_W'(DECODE_THRESH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [FW-1:0]          dis_cnt;
  logic                   filt_q;
  logic                   filt_d;
  logic                   synced;
  logic                   rise;
  logic                   fall;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] hi_lat;
  logic [CNT_W-1:0] high_q;
  logic [CNT_W-1:0] period_q;
  logic [7:0]       ctrl_q;
  logic             valid_q;
  logic             lost_q;

  assign synced  = sync_q[SYNC_STAGES-1];
  assign rise    = filt_q & ~filt_d;
  assign fall    = ~filt_q & filt_d;
  assign cnt_inc = (cnt == CNT_MAX) ? CNT_MAX : cnt + 1'b1;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sync_q  <= '0;
      dis_cnt <= '0;
      filt_q  <= 1'b0;
      filt_d  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pwm_in};
      filt_d <= filt_q;
      if (synced == filt_q) begin
        dis_cnt <= '0;
      end else if (dis_cnt == FILT_LAST) begin
        filt_q  <= synced;
        dis_cnt <= '0;
      end else begin
        dis_cnt <= dis_cnt + 1'b1;
      end
    end
  end

  // cnt reads 0 in the first cycle after a rise, so the latched durations
  // use cnt+1 to report the number of whole cycles actually elapsed.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      hi_lat   <= '0;
      high_q   <= '0;
      period_q <= '0;
      ctrl_q   <= '0;
      valid_q  <= 1'b0;
      lost_q   <= 1'b1;
    end else begin
      valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (rise) state <= ST_HIGH;
        end
        ST_HIGH: begin
          if (fall) begin
            hi_lat <= cnt_inc;
            cnt    <= cnt_inc;
            state  <= ST_LOW;
          end else if (cnt == TO_CNT) begin
            cnt    <= '0;
            lost_q <= 1'b1;
            state  <= ST_IDLE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        ST_LOW: begin
          if (rise) begin
            high_q   <= hi_lat;
            period_q <= cnt_inc;
            ctrl_q   <= (hi_lat > THRESH) ? 8'd2 : 8'd0;
            valid_q  <= 1'b1;
            lost_q   <= 1'b0;
            cnt      <= '0;
            state    <= ST_HIGH;
          end else if (cnt == TO_CNT) begin
            cnt    <= '0;
            lost_q <= 1'b1;
            state  <= ST_IDLE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          cnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.high_cnt    = high_q;
  assign bus.period_cnt  = period_q;
  assign bus.ctrl_out    = ctrl_q;
  assign bus.meas_valid  = valid_q;
  assign bus.signal_lost = lost_q;

endmodule
